// File: rtl/fifo_rr_reader_if.sv
// rtl/fifo_rr_reader_if.sv - FIFO-side bus between the round-robin reader and its input/output FIFO banks
//
// Purpose: bundles the input FIFO bank read side and the output FIFO bank write side
//          so the reader and its environment connect through one port.
// Signals:
//   in_empty    [NUM_CH]         fifo_empty of each input FIFO
//   in_data     [NUM_CH*DATA_W]  data_out of each input FIFO, FIFO i at [DATA_W*i +: DATA_W]
//   in_rd       [NUM_CH]         fifo_rd to each input FIFO
//   out_al_full [NUM_CH]         al_full of each output FIFO
//   out_full    [NUM_CH]         fifo_full of each output FIFO
//   out_wr      [NUM_CH]         fifo_wr to each output FIFO
//   out_data    [DATA_W]         write data shared by all output FIFOs
// Modports: master = the reader, slave = the FIFO banks.
interface fifo_rr_reader_if #(
    parameter int DATA_W = 6,
    parameter int NUM_CH = 4
);
    logic [NUM_CH-1:0]        in_empty;
    logic [NUM_CH*DATA_W-1:0] in_data;
    logic [NUM_CH-1:0]        in_rd;
    logic [NUM_CH-1:0]        out_al_full;
    logic [NUM_CH-1:0]        out_full;
    logic [NUM_CH-1:0]        out_wr;
    logic [DATA_W-1:0]        out_data;

    modport master (
        input  in_empty,
        input  in_data,
        input  out_al_full,
        input  out_full,
        output in_rd,
        output out_wr,
        output out_data
    );

    modport slave (
        output in_empty,
        output in_data,
        output out_al_full,
        output out_full,
        input  in_rd,
        input  out_wr,
        input  out_data
    );
endinterface

// File: rtl/fifo_rr_reader.sv
// rtl/fifo_rr_reader.sv - round-robin drain of four input FIFOs into four destination-selected output FIFOs
//
// Purpose: pops at most one word per cycle from the non-empty input FIFOs in round-robin
//          order, then forwards it two cycles later to the output FIFO named by the top
//          two data bits. Honours almost-full backpressure and flags pushes into full FIFOs.
// Ports:
//   clk        system clock, rising edge
//   RESET_L    asynchronous active-low reset
//   bus        FIFO-side bus (master): in_empty/in_data/in_rd, out_al_full/out_full/out_wr/out_data
//   active     high while the FSM is in ACTIVE
//   idle       all inputs empty and nothing in flight
//   err_out    sticky overflow flag, cleared only by reset
//   words_fwd  wrapping count of words pushed downstream
module fifo_rr_reader #(
    parameter int DATA_W = 6,
    parameter int NUM_CH = 4
) (
    input  logic             clk,
    input  logic             RESET_L,
    fifo_rr_reader_if.master bus,
    output logic             active,
    output logic             idle,
    output logic             err_out,
    output logic [7:0]       words_fwd
);
    localparam int PTR_W = $clog2(NUM_CH);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACTIVE = 1'b1
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [PTR_W-1:0]  rr_ptr;
    logic [PTR_W-1:0]  grant;
    logic [PTR_W-1:0]  grant_idx;
    logic              grant_valid;
    logic              pend_valid;
    logic [PTR_W-1:0]  pend_idx;
    logic              pause;
    logic [NUM_CH-1:0] req;
    logic [DATA_W-1:0] word;
    logic [PTR_W-1:0]  dest;

    assign pause = |bus.out_al_full;
    assign req   = ~bus.in_empty;

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if ((|req) && !pause) next_state = S_ACTIVE;
            S_ACTIVE: if (!(|req) || pause) next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    // Search downward in offset so the requester closest to rr_ptr is the last
    // (and therefore winning) assignment.
    always_comb begin
        grant_valid = 1'b0;
        grant       = '0;
        grant_idx   = '0;
        if (state == S_ACTIVE && !pause) begin
            for (int k = NUM_CH - 1; k >= 0; k--) begin
                grant_idx = rr_ptr + PTR_W'(k);
                if (req[grant_idx]) begin
                    grant_valid = 1'b1;
                    grant       = grant_idx;
                end
            end
        end
    end

    assign bus.in_rd = grant_valid ? (NUM_CH'(1) << grant) : '0;

    // The input FIFO presents the popped word one cycle after the read strobe.
    assign word = bus.in_data[pend_idx*DATA_W +: DATA_W];
    assign dest = word[DATA_W-1 -: PTR_W];

    assign idle = (state == S_IDLE) & ~pend_valid & ~(|bus.out_wr) & ~(|req);

    always_ff @(posedge clk or negedge RESET_L) begin
        if (!RESET_L) begin
            state  <= S_IDLE;
            active <= 1'b0;
        end else begin
            state  <= next_state;
            active <= (next_state == S_ACTIVE);
        end
    end

    always_ff @(posedge clk or negedge RESET_L) begin
        if (!RESET_L) begin
            rr_ptr       <= '0;
            pend_valid   <= 1'b0;
            pend_idx     <= '0;
            bus.out_wr   <= '0;
            bus.out_data <= '0;
            err_out      <= 1'b0;
            words_fwd    <= '0;
        end else begin
            if (grant_valid) begin
                rr_ptr <= grant + PTR_W'(1);
            end
            pend_valid <= grant_valid;
            pend_idx   <= grant;

            if (pend_valid) begin
                bus.out_data <= word;
                bus.out_wr   <= NUM_CH'(1) << dest;
                words_fwd    <= words_fwd + 8'd1;
            end else begin
                bus.out_wr   <= '0;
            end

            // Checked on the edge where the output FIFO samples the write strobe;
            // the word is still presented and the FIFO itself discards it.
            if (|(bus.out_wr & bus.out_full)) begin
                err_out <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fifo_rr_reader.sv
// tb/tb_fifo_rr_reader.sv - directed self-checking bench for fifo_rr_reader
module tb_fifo_rr_reader;
    logic       clk = 1'b0;
    logic       RESET_L = 1'b1;
    logic       active;
    logic       idle;
    logic       err_out;
    logic [7:0] words_fwd;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    fifo_rr_reader_if #(.DATA_W(6), .NUM_CH(4)) bus ();

    fifo_rr_reader #(.DATA_W(6), .NUM_CH(4)) dut (
        .clk       (clk),
        .RESET_L   (RESET_L),
        .bus       (bus),
        .active    (active),
        .idle      (idle),
        .err_out   (err_out),
        .words_fwd (words_fwd)
    );

    // Input FIFO models: mem/wc written by the stimulus, rp/dout by the read strobe.
    logic [5:0] mem  [4][256];
    logic [7:0] wc   [4];
    logic [7:0] rp   [4] = '{4{8'd0}};
    logic [5:0] dout [4] = '{4{6'd0}};

    for (genvar g = 0; g < 4; g++) begin : g_fifo
        assign bus.in_empty[g]        = (rp[g] == wc[g]);
        assign bus.in_data[6*g +: 6]  = dout[g];
    end

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (bus.in_rd[i] && !bus.in_empty[i]) begin
                dout[i] <= mem[i][rp[i]];
                rp[i]   <= rp[i] + 8'd1;
            end
        end
    end

    // Output side: log every push, and count protocol violations.
    int         cyc = 0;
    int         log_cnt = 0;
    logic [5:0] log_data [1024];
    logic [3:0] log_wr   [1024];
    int         log_cyc  [1024];
    int         bad_rd_empty = 0;
    int         bad_multi = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (|bus.out_wr) begin
            log_data[log_cnt] <= bus.out_data;
            log_wr[log_cnt]   <= bus.out_wr;
            log_cyc[log_cnt]  <= cyc;
            log_cnt           <= log_cnt + 1;
        end
        if (|(bus.in_rd & bus.in_empty)) bad_rd_empty <= bad_rd_empty + 1;
        if ($countones(bus.in_rd) > 1 || $countones(bus.out_wr) > 1) bad_multi <= bad_multi + 1;
    end

    task automatic push_word(input int f, input logic [5:0] w);
        mem[f][wc[f]] = w;
        wc[f] = wc[f] + 8'd1;
    endtask

    task automatic wait_rd(input string name);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            #1;
            if (bus.in_rd != 4'b0000) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!ok) $display("FAIL %s_timeout: no in_rd within 20 cycles", name);
        else passes++;
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            if (idle === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) $display("FAIL %s_idle_timeout: idle not reached in 600 cycles", name);
        else passes++;
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        RESET_L = 1'b0;
        @(negedge clk);
        RESET_L = 1'b1;
    endtask

    task automatic test_reset();
        #1 RESET_L = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (bus.in_rd !== 4'b0000) $display("FAIL rst_in_rd: got %b want 0000", bus.in_rd); else passes++;
        checks++; if (bus.out_wr !== 4'b0000) $display("FAIL rst_out_wr: got %b want 0000", bus.out_wr); else passes++;
        checks++; if (bus.out_data !== 6'h00) $display("FAIL rst_out_data: got %h want 00", bus.out_data); else passes++;
        checks++; if (err_out !== 1'b0) $display("FAIL rst_err: got %b want 0", err_out); else passes++;
        checks++; if (words_fwd !== 8'd0) $display("FAIL rst_words: got %0d want 0", words_fwd); else passes++;
        checks++; if (active !== 1'b0) $display("FAIL rst_active: got %b want 0", active); else passes++;
        checks++; if (idle !== 1'b1) $display("FAIL rst_idle: got %b want 1", idle); else passes++;
        RESET_L = 1'b1;
    endtask

    task automatic test_single();
        @(negedge clk);
        push_word(2, 6'b10_0101);
        wait_rd("single");
        checks++; if (bus.in_rd !== 4'b0100) $display("FAIL single_in_rd: got %b want 0100", bus.in_rd); else passes++;
        @(negedge clk);
        checks++; if (bus.out_wr !== 4'b0000) $display("FAIL single_wr_n1: got %b want 0000", bus.out_wr); else passes++;
        @(negedge clk);
        checks++; if (bus.out_wr !== 4'b0100) $display("FAIL single_wr_n2: got %b want 0100", bus.out_wr); else passes++;
        checks++; if (bus.out_data !== 6'h25) $display("FAIL single_data: got %h want 25", bus.out_data); else passes++;
        checks++; if (words_fwd !== 8'd1) $display("FAIL single_words: got %0d want 1", words_fwd); else passes++;
        checks++; if (idle !== 1'b0) $display("FAIL single_idle_n2: got %b want 0", idle); else passes++;
        @(negedge clk);
        checks++; if (bus.out_wr !== 4'b0000) $display("FAIL single_wr_n3: got %b want 0000", bus.out_wr); else passes++;
        checks++; if (idle !== 1'b1) $display("FAIL single_idle_n3: got %b want 1", idle); else passes++;
    endtask

    task automatic test_round_robin();
        logic [5:0] exp_w [8];
        logic [3:0] e;
        int base;
        reset_pulse();
        base = log_cnt;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 4; i++) begin
                exp_w[k*4+i] = {2'(3 - i), 2'(k), 2'(i)};
                push_word(i, exp_w[k*4+i]);
            end
        end
        wait_rd("rr");
        for (int s = 0; s < 8; s++) begin
            e = 4'b0001 << (s % 4);
            checks++; if (bus.in_rd !== e) $display("FAIL rr_order[%0d]: got %b want %b", s, bus.in_rd, e); else passes++;
            @(negedge clk);
            #1;
        end
        repeat (3) @(negedge clk);
        checks++; if (words_fwd !== 8'd8) $display("FAIL rr_words: got %0d want 8", words_fwd); else passes++;
        checks++; if (log_cnt - base !== 8) $display("FAIL rr_push_cnt: got %0d want 8", log_cnt - base); else passes++;
        for (int s = 0; s < 8; s++) begin
            e = 4'b0001 << exp_w[s][5:4];
            checks++;
            if (log_data[base+s] !== exp_w[s] || log_wr[base+s] !== e || log_cyc[base+s] - log_cyc[base] !== s)
                $display("FAIL rr_push[%0d]: got data %h wr %b dt %0d want data %h wr %b dt %0d", s,
                         log_data[base+s], log_wr[base+s], log_cyc[base+s] - log_cyc[base], exp_w[s], e, s);
            else passes++;
        end
    endtask

    task automatic test_pause();
        int base;
        logic [7:0] base_w;
        base   = log_cnt;
        base_w = words_fwd;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 3; i++) push_word(i, {2'd2, 2'(k), 2'(i)});
        end
        wait_rd("pause");
        checks++; if (bus.in_rd !== 4'b0001) $display("FAIL pause_first: got %b want 0001", bus.in_rd); else passes++;
        @(negedge clk);
        bus.out_al_full = 4'b0010;
        #1;
        checks++; if (bus.in_rd !== 4'b0000) $display("FAIL pause_no_pop: got %b want 0000", bus.in_rd); else passes++;
        checks++; if (active !== 1'b1) $display("FAIL pause_active_same: got %b want 1", active); else passes++;
        repeat (4) @(negedge clk);
        checks++; if (active !== 1'b0) $display("FAIL pause_active_drop: got %b want 0", active); else passes++;
        checks++; if (bus.in_rd !== 4'b0000) $display("FAIL pause_hold: got %b want 0000", bus.in_rd); else passes++;
        checks++; if (log_cnt - base !== 1) $display("FAIL pause_extra_push: got %0d want 1", log_cnt - base); else passes++;
        checks++; if (idle !== 1'b0) $display("FAIL pause_idle: got %b want 0", idle); else passes++;
        bus.out_al_full = 4'b0000;
        wait_rd("resume");
        checks++; if (bus.in_rd !== 4'b0010) $display("FAIL pause_resume_ptr: got %b want 0010", bus.in_rd); else passes++;
        wait_idle("pause");
        checks++; if (8'(words_fwd - base_w) !== 8'd9) $display("FAIL pause_words: got %0d want 9", 8'(words_fwd - base_w)); else passes++;
    endtask

    task automatic test_single_source();
        int base;
        base = log_cnt;
        for (int k = 0; k < 3; k++) push_word(3, {2'd1, 2'(k), 2'd3});
        wait_rd("solo");
        for (int s = 0; s < 3; s++) begin
            checks++; if (bus.in_rd !== 4'b1000) $display("FAIL solo_rd[%0d]: got %b want 1000", s, bus.in_rd); else passes++;
            @(negedge clk);
            #1;
        end
        checks++; if (bus.in_rd !== 4'b0000) $display("FAIL solo_done: got %b want 0000", bus.in_rd); else passes++;
        push_word(0, 6'h01);
        push_word(1, 6'h02);
        wait_rd("solo_ptr");
        checks++; if (bus.in_rd !== 4'b0001) $display("FAIL solo_ptr_wrap: got %b want 0001", bus.in_rd); else passes++;
        wait_idle("solo");
        checks++; if (log_cnt - base !== 5) $display("FAIL solo_push_cnt: got %0d want 5", log_cnt - base); else passes++;
        checks++;
        if (log_data[base] !== 6'h13 || log_wr[base] !== 4'b0010)
            $display("FAIL solo_first_push: got data %h wr %b want data 13 wr 0010", log_data[base], log_wr[base]);
        else passes++;
    endtask

    task automatic test_overflow();
        bus.out_full = 4'b1110;
        push_word(1, 6'h0A);
        wait_idle("ovf_clean");
        checks++; if (err_out !== 1'b0) $display("FAIL ovf_other_full: got %b want 0", err_out); else passes++;
        bus.out_full = 4'b0001;
        push_word(1, 6'h0B);
        wait_idle("ovf_hit");
        checks++; if (err_out !== 1'b1) $display("FAIL ovf_set: got %b want 1", err_out); else passes++;
        checks++; if (log_data[log_cnt-1] !== 6'h0B) $display("FAIL ovf_presented: got %h want 0b", log_data[log_cnt-1]); else passes++;
        bus.out_full = 4'b0000;
        push_word(2, 6'h2C);
        wait_idle("ovf_after");
        checks++; if (err_out !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", err_out); else passes++;
        reset_pulse();
        #1;
        checks++; if (err_out !== 1'b0) $display("FAIL ovf_clear: got %b want 0", err_out); else passes++;
    endtask

    task automatic test_reset_mid();
        int base;
        push_word(1, 6'h15);
        wait_rd("mid");
        base = log_cnt;
        @(negedge clk);
        RESET_L = 1'b0;
        #1;
        checks++; if (bus.out_wr !== 4'b0000) $display("FAIL mid_wr_in_rst: got %b want 0000", bus.out_wr); else passes++;
        checks++; if (active !== 1'b0) $display("FAIL mid_active_in_rst: got %b want 0", active); else passes++;
        @(negedge clk);
        RESET_L = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            checks++; if (bus.out_wr !== 4'b0000) $display("FAIL mid_stale_wr[%0d]: got %b want 0000", n, bus.out_wr); else passes++;
        end
        checks++; if (words_fwd !== 8'd0) $display("FAIL mid_words: got %0d want 0", words_fwd); else passes++;
        checks++; if (log_cnt !== base) $display("FAIL mid_push_cnt: got %0d want %0d", log_cnt, base); else passes++;
    endtask

    task automatic test_wrap();
        int base;
        reset_pulse();
        base = log_cnt;
        for (int k = 0; k < 64; k++) begin
            for (int i = 0; i < 4; i++) push_word(i, 6'(k + i));
        end
        wait_idle("wrap");
        checks++; if (log_cnt - base !== 256) $display("FAIL wrap_push_cnt: got %0d want 256", log_cnt - base); else passes++;
        checks++; if (words_fwd !== 8'd0) $display("FAIL wrap_words: got %0d want 0", words_fwd); else passes++;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) wc[i] = 8'd0;
        bus.out_al_full = 4'b0000;
        bus.out_full    = 4'b0000;
        test_reset();
        test_single();
        test_round_robin();
        test_pause();
        test_single_source();
        test_overflow();
        test_reset_mid();
        test_wrap();
        checks++; if (bad_rd_empty !== 0) $display("FAIL rd_on_empty: got %0d want 0", bad_rd_empty); else passes++;
        checks++; if (bad_multi !== 0) $display("FAIL multi_hot: got %0d want 0", bad_multi); else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
